mem_access_unit: RTL



---
 rtl/mem_access_unit_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage access engine: size masks and FSM state encodings.
package mem_access_unit_pkg;

  localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    MEMA_IDLE  = 2'd0,
    MEMA_BUSY  = 2'd1,
    MEMA_DRAIN = 2'd2,
    MEMA_DONE  = 2'd3
  } mema_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store replication, misalignment detection,
// and load byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [3:0]  ld_sel,
  input  logic [1:0]  ld_off,
  input  logic        ld_sign,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic       is_word;
  logic       is_half;
  logic       ld_word;
  logic       ld_half;
  logic [7:0]  ld_byte_val;
  logic [15:0] ld_half_val;

  assign is_word = (sel == MEM_SEL_WORD);
  assign is_half = (sel == MEM_SEL_HALF);

  assign be         = sel << addr_lo;
  assign misaligned = (is_word && (addr_lo != 2'b00)) || (is_half && addr_lo[0]);

  always_comb begin
    wdata = {4{store_data[7:0]}};
    if (is_word)      wdata = store_data;
    else if (is_half) wdata = {2{store_data[15:0]}};
  end

  // Load side uses the size/offset latched at request time, not the live inputs.
  assign ld_word = (ld_sel == MEM_SEL_WORD);
  assign ld_half = (ld_sel == MEM_SEL_HALF);

  always_comb begin
    ld_byte_val = rdata[7:0];
    case (ld_off)
      2'd0:    ld_byte_val = rdata[7:0];
      2'd1:    ld_byte_val = rdata[15:8];
      2'd2:    ld_byte_val = rdata[23:16];
      default: ld_byte_val = rdata[31:24];
    endcase
  end

  assign ld_half_val = ld_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = {{24{ld_sign & ld_byte_val[7]}}, ld_byte_val};
    if (ld_word)      load_data = rdata;
    else if (ld_half) load_data = {{16{ld_sign & ld_half_val[15]}}, ld_half_val};
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: alignment check, req/ack RAM handshake with timeout,
// pipeline stall generation and load-data extension.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] address,
  input  logic [31:0] mem_write_data,
  output logic        ram_req,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall_request,
  output logic        adel_flag,
  output logic        ades_flag,
  output logic [31:0] bad_vaddr,
  output logic        bus_err
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(ACK_TIMEOUT);

  mema_state_t state;
  mema_state_t state_next;

  logic        access;
  logic        is_write;
  logic        misaligned;
  logic        start;
  logic        timeout_hit;
  logic [7:0]  wait_cnt;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_c;
  logic [3:0]  ld_sel;
  logic [1:0]  ld_off;
  logic        ld_sign;

  assign access   = (mem_read_flag | mem_write_flag) & ~flush;
  assign is_write = mem_write_flag;
  assign start    = access & ~misaligned;
  // Timeout fires on the wait cycle that brings the count up to ACK_TIMEOUT.
  assign timeout_hit = ((wait_cnt + 8'd1) == TIMEOUT_LIMIT);

  mem_lane_align u_lane (
    .sel        (mem_sel),
    .addr_lo    (address[1:0]),
    .store_data (mem_write_data),
    .be         (be_c),
    .wdata      (wdata_c),
    .misaligned (misaligned),
    .ld_sel     (ld_sel),
    .ld_off     (ld_off),
    .ld_sign    (ld_sign),
    .rdata      (ram_rdata),
    .load_data  (load_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEMA_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MEMA_IDLE:  if (start) state_next = MEMA_BUSY;
      MEMA_BUSY: begin
        if (ram_ack || timeout_hit) state_next = MEMA_DONE;
        else if (flush)             state_next = MEMA_DRAIN;
      end
      MEMA_DRAIN: if (ram_ack || timeout_hit) state_next = MEMA_IDLE;
      MEMA_DONE:  state_next = MEMA_IDLE;
      default:    state_next = MEMA_IDLE;
    endcase
  end

  always_comb begin
    stall_request = 1'b0;
    adel_flag     = 1'b0;
    ades_flag     = 1'b0;
    case (state)
      MEMA_IDLE: begin
        stall_request = start;
        adel_flag     = access & misaligned & ~is_write;
        ades_flag     = access & misaligned & is_write;
      end
      MEMA_BUSY, MEMA_DRAIN: stall_request = 1'b1;
      default: stall_request = 1'b0;
    endcase
  end

  assign bad_vaddr = address;

  // Request/response registers; the request is never withdrawn before ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= 4'b0;
      ram_addr  <= 32'b0;
      ram_wdata <= 32'b0;
      load_data <= 32'b0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      wait_cnt  <= 8'b0;
      ld_sel    <= 4'b0;
      ld_off    <= 2'b0;
      ld_sign   <= 1'b0;
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        MEMA_IDLE: begin
          if (start) begin
            ram_req   <= 1'b1;
            ram_we    <= is_write;
            ram_be    <= be_c;
            ram_addr  <= {address[31:2], 2'b00};
            ram_wdata <= wdata_c;
            ld_sel    <= mem_sel;
            ld_off    <= address[1:0];
            ld_sign   <= mem_sign_flag;
            wait_cnt  <= 8'b0;
          end
        end
        MEMA_BUSY: begin
          if (ram_ack) begin
            ram_req   <= 1'b0;
            load_data <= load_c;
            done      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) begin
              ram_req   <= 1'b0;
              load_data <= 32'b0;
              done      <= 1'b1;
              bus_err   <= 1'b1;
            end
          end
        end
        MEMA_DRAIN: begin
          if (ram_ack || timeout_hit) ram_req <= 1'b0;
          if (!ram_ack)               wait_cnt <= wait_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
